// File: rtl/board_win_scanner_if.sv
// Handshake and result bundle for board_win_scanner: start/board in, busy/done/results out.
interface board_win_scanner_if #(parameter int N = 3) ();
  logic           start;
  logic [N*N-1:0] ain;
  logic [N*N-1:0] bin;
  logic           busy;
  logic           done;
  logic [1:0]     winner;
  logic [1:0]     win_dir;
  logic [2:0]     win_r;
  logic [2:0]     win_c;
  logic           draw;
  logic           illegal;

  modport master (
    output start, ain, bin,
    input  busy, done, winner, win_dir, win_r, win_c, draw, illegal
  );

  modport slave (
    input  start, ain, bin,
    output busy, done, winner, win_dir, win_r, win_c, draw, illegal
  );
endinterface

// File: rtl/board_win_scanner.sv
// Sequential N x N K-in-a-row scanner: one start cell per cycle, all four directions, both players.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for start; latches board and clears accumulators
//   S_SCAN | evaluates one start cell per cycle, r-major order
//   S_DONE | copies accumulated results to outputs, pulses done
module board_win_scanner #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic clk,
  input  logic reset_n,
  board_win_scanner_if.slave bus
);

  localparam int NN = N * N;
  localparam int BW = $clog2(NN);
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [NN-1:0] brd_a, brd_b;
  logic [2:0]    cell_r, cell_c;
  logic [1:0]    acc_win;
  logic [1:0]    acc_dir;
  logic [2:0]    acc_r, acc_c;
  logic          found;
  logic [3:0]    hit_a, hit_b, hit_any;
  logic [1:0]    first_dir;
  logic          last_cell;

  assign last_cell = (cell_r == LAST) && (cell_c == LAST);
  assign hit_any   = hit_a | hit_b;

  // Per-direction line test from the current start cell; runs leaving the board never hit.
  always_comb begin
    int r0, c0, rr, cc, bi;
    logic in_a, in_b;
    hit_a = '0;
    hit_b = '0;
    r0 = int'(cell_r);
    c0 = int'(cell_c);
    rr = 0;
    cc = 0;
    bi = 0;
    in_a = 1'b0;
    in_b = 1'b0;
    for (int d = 0; d < 4; d++) begin
      in_a = 1'b1;
      in_b = 1'b1;
      for (int i = 0; i < K; i++) begin
        rr = r0 + ((d == 0) ? 0 : i);
        cc = (d == 1) ? c0 : ((d == 3) ? c0 - i : c0 + i);
        if (rr >= N || cc < 0 || cc >= N) begin
          in_a = 1'b0;
          in_b = 1'b0;
        end else begin
          bi = NN - 1 - (rr * N + cc);
          in_a = in_a & brd_a[BW'(bi)];
          in_b = in_b & brd_b[BW'(bi)];
        end
      end
      hit_a[2'(d)] = in_a;
      hit_b[2'(d)] = in_b;
    end
  end

  always_comb begin
    first_dir = 2'd3;
    if (hit_any[0])      first_dir = 2'd0;
    else if (hit_any[1]) first_dir = 2'd1;
    else if (hit_any[2]) first_dir = 2'd2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_SCAN;
      S_SCAN:  if (last_cell) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brd_a       <= '0;
      brd_b       <= '0;
      cell_r      <= '0;
      cell_c      <= '0;
      acc_win     <= '0;
      acc_dir     <= '0;
      acc_r       <= '0;
      acc_c       <= '0;
      found       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.winner  <= '0;
      bus.win_dir <= '0;
      bus.win_r   <= '0;
      bus.win_c   <= '0;
      bus.draw    <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      bus.busy <= (state_nxt != S_IDLE);
      bus.done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            brd_a   <= bus.ain;
            brd_b   <= bus.bin;
            cell_r  <= '0;
            cell_c  <= '0;
            acc_win <= '0;
            acc_dir <= '0;
            acc_r   <= '0;
            acc_c   <= '0;
            found   <= 1'b0;
          end
        end
        S_SCAN: begin
          acc_win <= acc_win | {|hit_b, |hit_a};
          if (!found && (|hit_any)) begin
            found   <= 1'b1;
            acc_dir <= first_dir;
            acc_r   <= cell_r;
            acc_c   <= cell_c;
          end
          if (cell_c == LAST) begin
            cell_c <= '0;
            cell_r <= cell_r + 3'd1;
          end else begin
            cell_c <= cell_c + 3'd1;
          end
        end
        S_DONE: begin
          bus.winner  <= acc_win;
          bus.win_dir <= acc_dir;
          bus.win_r   <= acc_r;
          bus.win_c   <= acc_c;
          bus.draw    <= (&(brd_a | brd_b)) && (acc_win == 2'b00);
          bus.illegal <= |(brd_a & brd_b);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_win_scanner.sv
// Directed bench for board_win_scanner: a 3x3/K=3 and a 4x4/K=3 instance on one clock.
module tb_board_win_scanner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  board_win_scanner_if #(.N(3)) bus3 ();
  board_win_scanner_if #(.N(4)) bus4 ();

  board_win_scanner #(.N(3), .K(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
  board_win_scanner #(.N(4), .K(3)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a scan on the 3x3 instance and returns edges from accept to done (0 on timeout).
  task automatic scan3(input logic [8:0] a, input logic [8:0] b, output int lat, output bit hs_bad);
    @(negedge clk);
    bus3.ain = a; bus3.bin = b; bus3.start = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    lat = 0; hs_bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus3.done && bus3.busy) hs_bad = 1'b1;
      if (bus3.done) begin lat = i; break; end
      if (!bus3.busy) hs_bad = 1'b1;
    end
  endtask

  task automatic scan4(input logic [15:0] a, input logic [15:0] b, output int lat, output bit hs_bad);
    @(negedge clk);
    bus4.ain = a; bus4.bin = b; bus4.start = 1'b1;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    lat = 0; hs_bad = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus4.done && bus4.busy) hs_bad = 1'b1;
      if (bus4.done) begin lat = i; break; end
      if (!bus4.busy) hs_bad = 1'b1;
    end
  endtask

  task automatic expect3(input string tag, input logic [1:0] w, input logic [1:0] d,
                         input logic [2:0] r, input logic [2:0] c, input logic dr, input logic il);
    check({tag, ".winner"},  32'(bus3.winner),  32'(w));
    check({tag, ".win_dir"}, 32'(bus3.win_dir), 32'(d));
    check({tag, ".win_rc"},  {bus3.win_r, bus3.win_c}, {r, c});
    check({tag, ".draw"},    32'(bus3.draw),    32'(dr));
    check({tag, ".illegal"}, 32'(bus3.illegal), 32'(il));
  endtask

  task automatic expect4(input string tag, input logic [1:0] w, input logic [1:0] d,
                         input logic [2:0] r, input logic [2:0] c);
    check({tag, ".winner"},  32'(bus4.winner),  32'(w));
    check({tag, ".win_dir"}, 32'(bus4.win_dir), 32'(d));
    check({tag, ".win_rc"},  {bus4.win_r, bus4.win_c}, {r, c});
    check({tag, ".draw"},    32'(bus4.draw),    32'd0);
    check({tag, ".illegal"}, 32'(bus4.illegal), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  hs_bad;
    int  n_done;
    bit  overlap;
    logic [1:0] w_first;

    bus3.start = 1'b0; bus3.ain = '0; bus3.bin = '0;
    bus4.start = 1'b0; bus4.ain = '0; bus4.bin = '0;
    #2;
    check("rst.busy", 32'(bus3.busy), 32'd0);
    check("rst.done", 32'(bus3.done), 32'd0);
    expect3("rst", 2'b00, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // A top row
    scan3(9'b111000000, 9'b000000000, lat, hs_bad);
    check("rowA.latency", 32'(lat), 32'd10);
    check("rowA.handshake", 32'(hs_bad), 32'd0);
    expect3("rowA", 2'b01, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // B up-diagonal from (0,2)
    scan3(9'b000000000, 9'b001010100, lat, hs_bad);
    check("upB.latency", 32'(lat), 32'd10);
    expect3("upB", 2'b10, 2'd3, 3'd0, 3'd2, 1'b0, 1'b0);

    // Full board, no line
    scan3(9'b110001101, 9'b001110010, lat, hs_bad);
    expect3("draw", 2'b00, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0);

    // Both win; A row 0 precedes B row 2
    scan3(9'b111000000, 9'b000000111, lat, hs_bad);
    expect3("both", 2'b11, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);

    // Overlapping cell
    scan3(9'b000000001, 9'b000000001, lat, hs_bad);
    expect3("illegal", 2'b00, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1);

    // 4x4: A down-diagonal (1,1)-(3,3)
    scan4(16'b0000_0100_0010_0001, 16'h0000, lat, hs_bad);
    check("diag4.latency", 32'(lat), 32'd17);
    check("diag4.handshake", 32'(hs_bad), 32'd0);
    expect4("diag4", 2'b01, 2'd2, 3'd1, 3'd1);

    // 4x4: A row starting (0,1)
    scan4(16'b0111_0000_0000_0000, 16'h0000, lat, hs_bad);
    expect4("row4", 2'b01, 2'd0, 3'd0, 3'd1);

    // 4x4: B column starting (1,3)
    scan4(16'h0000, 16'b0000_0001_0001_0001, lat, hs_bad);
    expect4("col4", 2'b10, 2'd1, 3'd1, 3'd3);

    // start held for 15 edges: two acceptances; ain change mid-scan ignored
    @(negedge clk);
    bus3.ain = 9'b111000000; bus3.bin = 9'b000000000; bus3.start = 1'b1;
    @(posedge clk);
    n_done = 0; overlap = 1'b0; w_first = 2'b11;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin bus3.ain = 9'b000000000; bus3.bin = 9'b000000111; end
      if (i == 14) bus3.start = 1'b0;
      if (bus3.done) n_done++;
      if (bus3.done && bus3.busy) overlap = 1'b1;
      if (i == 10) w_first = bus3.winner;
    end
    check("hold.first_winner", 32'(w_first), 32'(2'b01));
    check("hold.done_count", 32'(n_done), 32'd2);
    check("hold.overlap", 32'(overlap), 32'd0);
    expect3("hold.second", 2'b10, 2'd0, 3'd2, 3'd0, 1'b0, 1'b0);

    // Reset at scan cycle 4 wipes held results
    @(negedge clk);
    bus3.ain = 9'b111000000; bus3.bin = 9'b000000000; bus3.start = 1'b1;
    @(posedge clk);
    #1 bus3.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus3.busy), 32'd0);
    check("abort.done", 32'(bus3.done), 32'd0);
    expect3("abort", 2'b00, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    scan3(9'b000000000, 9'b000111000, lat, hs_bad);
    check("fresh.latency", 32'(lat), 32'd10);
    expect3("fresh", 2'b10, 2'd0, 3'd1, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_win_scanner.md
# board_win_scanner

Parametrised, sequential successor to the combinational tic-tac-toe winner detector. It scans an N×N board for K-in-a-row lines of player A or B, one cell per cycle, under a start/done handshake. It reports the winner set, the location and direction of the first winning line, a draw flag and an illegal-board flag. It sits between the game-state registers and the display/score logic of the board game datapath.

## Interface
- N, default 3: board side; legal range 3..8.
- K, default 3: win length; legal range 3..N.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- ain  in  N*N  player A occupancy.
- bin  in  N*N  player B occupancy.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when results are valid.
- winner  out  2  bit0 = A has a line; bit1 = B has a line.
- win_dir  out  2  first line found: 0 row, 1 column, 2 down-diagonal, 3 up-diagonal.
- win_r, win_c  out  3 each  row and column of the first line's start cell.
- draw  out  1  board full (ain|bin all ones) and winner==0.
- illegal  out  1  (ain & bin) != 0.

## Operation
- Cell (r,c) maps to bit N*N-1-(r*N+c). Row 0 therefore occupies the MSBs. For N=3, row 0 is bits 8,7,6.
- Directions from a start cell (r,c):
  - row: (r, c..c+K-1)
  - column: (r..r+K-1, c)
  - down-diagonal: (r+i, c+i)
  - up-diagonal: (r+i, c-i)
- A direction whose run leaves the board is not a line.
- FSM states:
  - IDLE: start=1 latches ain/bin into internal board registers, clears cell counter and result accumulators → SCAN.
  - SCAN: each cycle evaluates all four directions at cell counter index i (scan order r-major, c-minor) for both players. Counter increments; after i = N*N-1 → DONE.
  - DONE: done=1 for one cycle, outputs update → IDLE.
- winner accumulates (OR) over the whole scan. There is no early termination, so latency is fixed.
- First-line priority, highest first: lower cell index; then direction order row, col, down, up; then A before B. win_dir/win_r/win_c are captured once on the first hit and hold for the rest of the scan.
- If winner==0: win_dir=0, win_r=0, win_c=0.
- illegal and draw are computed from the latched board. The scan proceeds regardless of illegal.
- ain/bin changes during SCAN have no effect.
- start in SCAN or DONE is ignored.
- Result outputs hold their values until the next DONE.

## Timing
- reset_n low, asynchronously: state=IDLE, busy=0, done=0, winner=0, win_dir=0, win_r=0, win_c=0, draw=0, illegal=0, counter=0.
- start sampled high at edge T:
  - busy=1 from T through edge T+N*N.
  - done=1 and new results visible in the cycle after edge T+N*N+1. Latency is N*N+1 edges; for N=3, done follows 10 edges after start.
- busy and done are never high together.
- Next start is accepted in the cycle after done.
- reset_n asserted mid-SCAN aborts the scan. All outputs return to reset values; the previous results are lost.
- All outputs are registered.

## Test plan
- N=3,K=3: ain=9'b111000000, bin=0, start → after 10 edges done=1, winner=01, win_dir=0, (r,c)=(0,0), draw=0, illegal=0.
- N=3: ain=0, bin=9'b001010100 → winner=10, win_dir=3, (r,c)=(0,2). Then ain=9'b110001101, bin=9'b001110010 → winner=00, draw=1.
- N=3: ain=9'b111000000, bin=9'b000000111 → winner=11, win_dir=0, (r,c)=(0,0) (A first). ain=bin=9'b000000001 → illegal=1, winner=00.
- N=4,K=3: ain has cells (1,1),(2,2),(3,3) set → winner=01, win_dir=2, (r,c)=(1,1), done 17 edges after start. Also ain with (0,1),(0,2),(0,3) set → row at (0,1).
- Handshake: start held high through the whole scan → exactly one done pulse per IDLE acceptance. ain changed mid-scan → results reflect the latched board.
- reset_n pulsed low at scan cycle 4 → busy=0 and all outputs 0 immediately. A fresh start afterwards completes with correct results.
